// File: rtl/clk_div_sync.sv
// Programmable integer divider on clk_mux1 with a toggle-handshake ratio update.
// New ratios take effect only at a period boundary, so clk_o never produces a runt phase.
module clk_div_sync #(
   parameter int CNT_W   = 8,
   parameter int DEF_DIV = 2
) (
   input  logic             clk_mux1,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] div_val,
   input  logic             req_tgl,
   output logic             ack_tgl,
   output logic             clk_o,
   output logic             clk_en,
   output logic             busy
);

   typedef enum logic {RUN, PEND} state_t;

   state_t           state, state_nxt;
   logic             req_meta, req_s;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] ratio, ratio_nxt;
   logic [CNT_W-1:0] shadow;
   logic             pending, wrap, capture, load;

   assign pending = (req_s != ack_tgl);
   assign wrap    = (cnt == ratio - CNT_W'(1));

   always_ff @(posedge clk_mux1 or negedge rst_n) begin
      if (!rst_n) begin
         req_meta <= 1'b0;
         req_s    <= 1'b0;
      end else begin
         req_meta <= req_tgl;
         req_s    <= req_meta;
      end
   end

   always_ff @(posedge clk_mux1 or negedge rst_n) begin
      if (!rst_n) state <= RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      load      = 1'b0;
      case (state)
         RUN: begin
            if (pending) begin
               state_nxt = PEND;
               capture   = 1'b1;
            end
         end
         PEND: begin
            if (wrap) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         default: state_nxt = RUN;
      endcase
   end

   // A load always coincides with wrap, so the new period starts from cnt=0 either way.
   assign cnt_nxt   = wrap ? '0 : cnt + CNT_W'(1);
   assign ratio_nxt = load ? shadow : ratio;

   always_ff @(posedge clk_mux1 or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         ratio   <= CNT_W'(DEF_DIV);
         shadow  <= CNT_W'(DEF_DIV);
         busy    <= 1'b0;
         ack_tgl <= 1'b0;
         clk_en  <= 1'b0;
         clk_o   <= 1'b0;
      end else begin
         cnt    <= cnt_nxt;
         ratio  <= ratio_nxt;
         clk_en <= wrap;
         // Use the incoming ratio so the first period after a load already has the new shape.
         clk_o  <= (ratio_nxt >= CNT_W'(2)) && (cnt_nxt < (ratio_nxt >> 1));
         if (capture) begin
            shadow <= (div_val == '0) ? CNT_W'(1) : div_val;
            busy   <= 1'b1;
         end else if (load) begin
            busy   <= 1'b0;
         end
         if (load) ack_tgl <= req_s;
      end
   end

endmodule

// File: tb/tb_clk_div_sync.sv
// Directed bench for clk_div_sync: reset, ratio changes through the toggle handshake,
// ratio-1 and maximum-ratio boundaries, and reset while a change is pending.
module tb_clk_div_sync;

   logic       clk_mux1;
   logic       rst_n;
   logic [7:0] div_val;
   logic       req_tgl;
   logic       ack_tgl;
   logic       clk_o;
   logic       clk_en;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   clk_div_sync #(.CNT_W(8), .DEF_DIV(2)) dut (
      .clk_mux1 (clk_mux1),
      .rst_n    (rst_n),
      .div_val  (div_val),
      .req_tgl  (req_tgl),
      .ack_tgl  (ack_tgl),
      .clk_o    (clk_o),
      .clk_en   (clk_en),
      .busy     (busy)
   );

   initial clk_mux1 = 1'b0;
   always #5 clk_mux1 = ~clk_mux1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      logic e;
      rst_n   = 1'b0;
      req_tgl = 1'b0;
      div_val = 8'd2;
      repeat (3) @(negedge clk_mux1);
      n_checks++; if (clk_o !== 1'b0)   begin n_fail++; $display("FAIL rst_clk_o: got %b expected 0", clk_o); end
      n_checks++; if (clk_en !== 1'b0)  begin n_fail++; $display("FAIL rst_clk_en: got %b expected 0", clk_en); end
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
      n_checks++; if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b expected 0", ack_tgl); end
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_mux1);
         e = ((k % 2) == 0);
         n_checks++; if (clk_o !== e)  begin n_fail++; $display("FAIL div2_clk_o k=%0d: got %b expected %b", k, clk_o, e); end
         n_checks++; if (clk_en !== e) begin n_fail++; $display("FAIL div2_clk_en k=%0d: got %b expected %b", k, clk_en, e); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div2_busy k=%0d: got %b expected 0", k, busy); end
      end
   endtask

   task automatic test_div5();
      int n;
      bit got;
      logic eo, ee;
      div_val = 8'd5;
      req_tgl = ~req_tgl;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_mux1);
         n++;
         if (busy) break;
      end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div5_busy_rise: got %b expected 1", busy); end
      n_checks++; if (n < 2 || n > 3) begin n_fail++; $display("FAIL div5_busy_latency: got %0d cycles expected 2..3", n); end
      n_checks++; if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL div5_ack_early: got %b expected 0", ack_tgl); end
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk_mux1);
         if (ack_tgl === req_tgl) begin got = 1'b1; break; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL div5_ack: got %b expected %b", ack_tgl, req_tgl); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div5_busy_fall: got %b expected 0", busy); end
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk_mux1);
         eo = ((k % 5) < 2);
         ee = ((k % 5) == 0);
         n_checks++; if (clk_o !== eo)  begin n_fail++; $display("FAIL div5_clk_o k=%0d: got %b expected %b", k, clk_o, eo); end
         n_checks++; if (clk_en !== ee) begin n_fail++; $display("FAIL div5_clk_en k=%0d: got %b expected %b", k, clk_en, ee); end
      end
   endtask

   task automatic test_div0();
      int n;
      bit got;
      div_val = 8'd4;
      req_tgl = ~req_tgl;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_mux1);
         if (ack_tgl === req_tgl) begin got = 1'b1; break; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL div4_ack: got %b expected %b", ack_tgl, req_tgl); end
      // toggle at cnt=0 of /4: sync takes 2 edges, PEND on the 3rd, load at the wrap on the 4th
      div_val = 8'd0;
      req_tgl = ~req_tgl;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_mux1);
         n++;
         if (ack_tgl === req_tgl) break;
      end
      n_checks++; if (ack_tgl !== req_tgl) begin n_fail++; $display("FAIL div0_ack: got %b expected %b", ack_tgl, req_tgl); end
      n_checks++; if (n != 4) begin n_fail++; $display("FAIL div0_load_cycle: got %0d expected 4", n); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL div0_busy: got %b expected 0", busy); end
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge clk_mux1);
         n_checks++; if (clk_o !== 1'b0)  begin n_fail++; $display("FAIL div1_clk_o k=%0d: got %b expected 0", k, clk_o); end
         n_checks++; if (clk_en !== 1'b1) begin n_fail++; $display("FAIL div1_clk_en k=%0d: got %b expected 1", k, clk_en); end
      end
   endtask

   task automatic test_from1_to3();
      int n;
      logic e;
      div_val = 8'd3;
      req_tgl = ~req_tgl;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_mux1);
         n++;
         if (ack_tgl === req_tgl) break;
      end
      n_checks++; if (ack_tgl !== req_tgl) begin n_fail++; $display("FAIL div3_ack: got %b expected %b", ack_tgl, req_tgl); end
      n_checks++; if (n != 4) begin n_fail++; $display("FAIL div3_load_cycle: got %0d expected 4", n); end
      for (int k = 0; k < 9; k++) begin
         if (k > 0) @(negedge clk_mux1);
         e = ((k % 3) == 0);
         n_checks++; if (clk_o !== e)  begin n_fail++; $display("FAIL div3_clk_o k=%0d: got %b expected %b", k, clk_o, e); end
         n_checks++; if (clk_en !== e) begin n_fail++; $display("FAIL div3_clk_en k=%0d: got %b expected %b", k, clk_en, e); end
      end
   endtask

   task automatic test_div255();
      bit got;
      logic eo, ee;
      logic [7:0] ec;
      div_val = 8'd255;
      req_tgl = ~req_tgl;
      got = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk_mux1);
         if (ack_tgl === req_tgl) begin got = 1'b1; break; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL div255_ack: got %b expected %b", ack_tgl, req_tgl); end
      for (int k = 0; k < 510; k++) begin
         if (k > 0) @(negedge clk_mux1);
         eo = ((k % 255) < 127);
         ee = ((k % 255) == 0);
         ec = 8'(k % 255);
         n_checks++; if (clk_o !== eo)   begin n_fail++; $display("FAIL div255_clk_o k=%0d: got %b expected %b", k, clk_o, eo); end
         n_checks++; if (clk_en !== ee)  begin n_fail++; $display("FAIL div255_clk_en k=%0d: got %b expected %b", k, clk_en, ee); end
         n_checks++; if (dut.cnt !== ec) begin n_fail++; $display("FAIL div255_cnt k=%0d: got %0d expected %0d", k, dut.cnt, ec); end
      end
   endtask

   task automatic test_reset_mid_pend();
      bit got;
      logic e;
      div_val = 8'd7;
      req_tgl = ~req_tgl;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk_mux1);
         if (ack_tgl === req_tgl) begin got = 1'b1; break; end
      end
      n_checks++; if (!got) begin n_fail++; $display("FAIL div7_ack: got %b expected %b", ack_tgl, req_tgl); end
      div_val = 8'd3;
      req_tgl = ~req_tgl;
      repeat (3) @(negedge clk_mux1);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy: got %b expected 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (clk_o !== 1'b0)   begin n_fail++; $display("FAIL async_rst_clk_o: got %b expected 0", clk_o); end
      n_checks++; if (clk_en !== 1'b0)  begin n_fail++; $display("FAIL async_rst_clk_en: got %b expected 0", clk_en); end
      n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
      n_checks++; if (ack_tgl !== 1'b0) begin n_fail++; $display("FAIL async_rst_ack: got %b expected 0", ack_tgl); end
      req_tgl = 1'b0;
      @(negedge clk_mux1);
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk_mux1);
         e = ((k % 2) == 0);
         n_checks++; if (clk_o !== e)  begin n_fail++; $display("FAIL resume_clk_o k=%0d: got %b expected %b", k, clk_o, e); end
         n_checks++; if (clk_en !== e) begin n_fail++; $display("FAIL resume_clk_en k=%0d: got %b expected %b", k, clk_en, e); end
         n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL resume_busy k=%0d: got %b expected 0", k, busy); end
      end
   endtask

   initial begin
      test_reset();
      test_div5();
      test_div0();
      test_from1_to3();
      test_div255();
      test_reset_mid_pend();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
